// File: rtl/dcache_ctrl.sv
// Miss/write sequencer for a direct-mapped, write-through, no-write-allocate data cache.
// Load hits complete with zero added latency; misses and stores go through the memory port.
module dcache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  output logic                  cache_wr_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  typedef enum logic [1:0] {IDLE, RD_MISS, RD_RESP, WR_MEM} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  // Outputs are decoded combinationally from state and request so a load hit
  // returns data and a miss stalls in the very cycle the request appears.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    stall_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    cache_wr_o    = 1'b0;
    cache_wdata_o = data_q;
    rdata_o       = cache_rdata_i;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_we_i) begin
            stall_o = 1'b1;
            state_d = WR_MEM;
          end else if (cache_hit_i) begin
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          end else begin
            stall_o = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          data_d  = mem_rdata_i;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        cache_wr_o = 1'b1;
        rdata_o    = data_q;
        state_d    = IDLE;
      end
      WR_MEM: begin
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        cache_wdata_o = req_wdata_i;
        // No-write-allocate: only a line that already holds the address is updated.
        if (mem_ack_i) begin
          cache_wr_o = cache_hit_i;
          state_d    = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o  = req_addr_i;
  assign mem_wdata_o = req_wdata_i;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table, directed corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_dcache_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we, cache_hit, mem_ack;
  logic [DW-1:0] req_addr, req_wdata, cache_rdata, mem_rdata;
  logic [DW-1:0] rdata, cache_wdata, mem_addr, mem_wdata;
  logic          stall, cache_wr, mem_req, mem_we;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rdata_o(rdata), .stall_o(stall),
    .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata),
    .cache_wr_o(cache_wr), .cache_wdata_o(cache_wdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 unit after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [DW-1:0] a,
                         input logic [DW-1:0] wd, input logic h, input logic [DW-1:0] crd);
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; cache_hit = h; cache_rdata = crd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic          valid;
    logic          we;
    logic          hit;
    logic          ack;
    logic [DW-1:0] crd;
    logic          exp_stall;
    logic          chk_rd;
  } vec_t;

  vec_t vecs[6];

  // Reference model state: saturating load hit/miss counts.
  int m_hit, m_miss;

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, d, lat;
    logic          hit_r, is_load, is_store;
    logic [DW-1:0] a, wd, crd, mrd;

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    set_req(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    do_reset();

    // Reset state
    settle();
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_cache_wr", {31'b0, cache_wr}, 0);
    chk("rst_hit_cnt", {28'b0, hit_cnt}, 0);
    chk("rst_miss_cnt", {28'b0, miss_cnt}, 0);

    // Single-cycle IDLE decode table; each vector is followed by a reset.
    vecs[0] = '{valid:1'b0, we:1'b0, hit:1'b0, ack:1'b0, crd:32'h0000_0000, exp_stall:1'b0, chk_rd:1'b0};
    vecs[1] = '{valid:1'b1, we:1'b0, hit:1'b1, ack:1'b0, crd:32'hCAFE_F00D, exp_stall:1'b0, chk_rd:1'b1};
    vecs[2] = '{valid:1'b1, we:1'b0, hit:1'b0, ack:1'b0, crd:32'h1111_2222, exp_stall:1'b1, chk_rd:1'b0};
    vecs[3] = '{valid:1'b1, we:1'b1, hit:1'b1, ack:1'b0, crd:32'h3333_4444, exp_stall:1'b1, chk_rd:1'b0};
    vecs[4] = '{valid:1'b1, we:1'b1, hit:1'b0, ack:1'b1, crd:32'h5555_6666, exp_stall:1'b1, chk_rd:1'b0};
    vecs[5] = '{valid:1'b1, we:1'b0, hit:1'b1, ack:1'b1, crd:32'h7777_8888, exp_stall:1'b0, chk_rd:1'b1};
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].valid, vecs[i].we, 32'h80, 32'h99, vecs[i].hit, vecs[i].crd);
      mem_ack = vecs[i].ack;
      settle();
      chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_mem_req", i), {31'b0, mem_req}, 0);
      chk($sformatf("vec%0d_cache_wr", i), {31'b0, cache_wr}, 0);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].crd);
      next_cycle();
      mem_ack = 1'b0;
      set_req(1'b0, 1'b0, '0, '0, 1'b0, '0);
      do_reset();
    end

    // 1: load hit
    set_req(1'b1, 1'b0, 32'h100, '0, 1'b1, 32'hDEAD_BEEF);
    settle();
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_stall", {31'b0, stall}, 0);
    chk("t1_mem_req", {31'b0, mem_req}, 0);
    next_cycle();
    set_req(1'b0, 1'b0, '0, '0, 1'b0, '0);
    settle();
    chk("t1_hit_cnt", {28'b0, hit_cnt}, 1);

    // 2: load miss, ack three cycles after the request
    next_cycle();
    set_req(1'b1, 1'b0, 32'h204, '0, 1'b0, 32'hBAD0_BAD0);
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 3);
      mem_rdata = (c == 3) ? 32'h1234_5678 : 32'hFFFF_0000;
      settle();
      chk($sformatf("t2_stall_c%0d", c), {31'b0, stall}, 1);
      chk($sformatf("t2_mem_req_c%0d", c), {31'b0, mem_req}, (c == 0) ? 0 : 1);
      if (c > 0) begin
        chk("t2_mem_we", {31'b0, mem_we}, 0);
        chk("t2_mem_addr", mem_addr, 32'h204);
      end
      next_cycle();
    end
    mem_ack = 1'b0;
    settle();
    chk("t2_resp_stall", {31'b0, stall}, 0);
    chk("t2_resp_cache_wr", {31'b0, cache_wr}, 1);
    chk("t2_resp_wdata", cache_wdata, 32'h1234_5678);
    chk("t2_resp_rdata", rdata, 32'h1234_5678);
    next_cycle();
    set_req(1'b0, 1'b0, '0, '0, 1'b0, '0);
    settle();
    chk("t2_miss_cnt", {28'b0, miss_cnt}, 1);
    chk("t2_cache_wr_after", {31'b0, cache_wr}, 0);

    // 3: store hit, ack after two cycles
    next_cycle();
    set_req(1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5, 1'b1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      mem_ack = (c == 2);
      settle();
      chk($sformatf("t3_stall_c%0d", c), {31'b0, stall}, (c == 2) ? 0 : 1);
      chk($sformatf("t3_cache_wr_c%0d", c), {31'b0, cache_wr}, (c == 2) ? 1 : 0);
      if (c > 0) begin
        chk("t3_mem_req", {31'b0, mem_req}, 1);
        chk("t3_mem_we", {31'b0, mem_we}, 1);
        chk("t3_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      end
      if (c == 2) chk("t3_cache_wdata", cache_wdata, 32'hA5A5_A5A5);
      next_cycle();
    end
    mem_ack = 1'b0;

    // 4: store miss
    set_req(1'b1, 1'b1, 32'h44, 32'h0F0F_0F0F, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      mem_ack = (c == 2);
      settle();
      chk($sformatf("t4_cache_wr_c%0d", c), {31'b0, cache_wr}, 0);
      if (c > 0) chk("t4_mem_we", {31'b0, mem_we & mem_req}, 1);
      next_cycle();
    end
    mem_ack = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, 1'b0, '0);
    settle();
    chk("t4_hit_cnt", {28'b0, hit_cnt}, 1);
    chk("t4_miss_cnt", {28'b0, miss_cnt}, 1);

    // 5: reset while waiting on a read miss, then a stale ack
    next_cycle();
    set_req(1'b1, 1'b0, 32'h300, '0, 1'b0, '0);
    next_cycle();
    settle();
    chk("t5_mem_req_pending", {31'b0, mem_req}, 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, 1'b0, '0);
    mem_ack = 1'b1;
    mem_rdata = 32'hDDDD_DDDD;
    settle();
    chk("t5_mem_req", {31'b0, mem_req}, 0);
    chk("t5_stall", {31'b0, stall}, 0);
    chk("t5_cache_wr", {31'b0, cache_wr}, 0);
    next_cycle();
    mem_ack = 1'b0;
    settle();
    chk("t5_cache_wr_after", {31'b0, cache_wr}, 0);
    chk("t5_hit_cnt", {28'b0, hit_cnt}, 0);
    chk("t5_miss_cnt", {28'b0, miss_cnt}, 0);

    // 6: hit counter saturation
    next_cycle();
    for (int c = 0; c < 16; c++) begin
      set_req(1'b1, 1'b0, 32'h10, '0, 1'b1, 32'h1);
      settle();
      if (c == 15) chk("t6_hit_cnt_15", {28'b0, hit_cnt}, 15);
      next_cycle();
    end
    set_req(1'b0, 1'b0, '0, '0, 1'b0, '0);
    settle();
    chk("t6_hit_cnt_sat", {28'b0, hit_cnt}, 15);

    // Randomized transactions against the transaction-level model
    do_reset();
    m_hit = 0;
    m_miss = 0;
    for (int t = 0; t < 300; t++) begin
      k     = $urandom_range(0, 3);
      a     = {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
      wd    = $urandom;
      crd   = $urandom;
      mrd   = $urandom;
      hit_r = 1'($urandom_range(0, 1));
      lat   = $urandom_range(0, 4);
      is_load  = (k == 1 || k == 2);
      is_store = (k == 3);
      $display("txn %0d kind=%0d addr=%h hit=%0d lat=%0d", t, k, a, hit_r, lat);

      set_req(k != 0, is_store, a, wd, hit_r, crd);
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      settle();
      chk("r_hit_cnt", {28'b0, hit_cnt}, m_hit);
      chk("r_miss_cnt", {28'b0, miss_cnt}, m_miss);
      chk("r_idle_stall", {31'b0, stall}, {31'b0, is_store | (is_load & ~hit_r)});
      chk("r_idle_mem_req", {31'b0, mem_req}, 0);
      chk("r_idle_cache_wr", {31'b0, cache_wr}, 0);
      if (is_load && hit_r) chk("r_hit_rdata", rdata, crd);
      if (is_load) begin
        if (hit_r) m_hit = sat_inc(m_hit);
        else m_miss = sat_inc(m_miss);
      end
      next_cycle();

      if (is_load && !hit_r) begin
        for (int c = 1; c <= lat + 1; c++) begin
          d = (c == lat + 1) ? 1 : 0;
          mem_ack = d[0];
          mem_rdata = d[0] ? mrd : $urandom;
          cache_hit = 1'($urandom_range(0, 1));
          cache_rdata = $urandom;
          settle();
          chk("r_rm_stall", {31'b0, stall}, 1);
          chk("r_rm_mem_req", {31'b0, mem_req}, 1);
          chk("r_rm_mem_we", {31'b0, mem_we}, 0);
          chk("r_rm_mem_addr", mem_addr, a);
          chk("r_rm_cache_wr", {31'b0, cache_wr}, 0);
          next_cycle();
        end
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        settle();
        chk("r_resp_stall", {31'b0, stall}, 0);
        chk("r_resp_cache_wr", {31'b0, cache_wr}, 1);
        chk("r_resp_wdata", cache_wdata, mrd);
        chk("r_resp_rdata", rdata, mrd);
        chk("r_resp_mem_req", {31'b0, mem_req}, 0);
        next_cycle();
      end

      if (is_store) begin
        for (int c = 1; c <= lat + 1; c++) begin
          d = (c == lat + 1) ? 1 : 0;
          mem_ack = d[0];
          settle();
          chk("r_wr_mem_req", {31'b0, mem_req}, 1);
          chk("r_wr_mem_we", {31'b0, mem_we}, 1);
          chk("r_wr_mem_addr", mem_addr, a);
          chk("r_wr_mem_wdata", mem_wdata, wd);
          chk("r_wr_stall", {31'b0, stall}, {31'b0, ~d[0]});
          chk("r_wr_cache_wr", {31'b0, cache_wr}, {31'b0, d[0] & hit_r});
          if (d[0] && hit_r) chk("r_wr_cache_wdata", cache_wdata, wd);
          next_cycle();
        end
      end
      mem_ack = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
